// File: rtl/nerv_button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nerv_button_pkg
// Description : Shared constants for the nervsoc pushbutton input block:
//               register word offsets and the channel-count ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package nerv_button_pkg;

  // Register select values taken from bus_addr[3:2]
  localparam logic [1:0] REG_STATE   = 2'd0;
  localparam logic [1:0] REG_PRESS   = 2'd1;
  localparam logic [1:0] REG_RELEASE = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  // Channels are packed into one 32-bit register word
  localparam int MAX_N_BTN = 32;

endpackage : nerv_button_pkg
`default_nettype wire

// File: rtl/nerv_debounce.sv
`default_nettype none
// ============================================================================
// Module      : nerv_debounce
// Description : One pushbutton channel. Normalises polarity (pressed = 1),
//               synchronises with two flops, and accepts a new level only
//               after it has been held for DEBOUNCE_CYCLES cycles. The
//               rise/fall strobes are high in the cycle that precedes the
//               stable update, so a consumer latching them sees the event
//               on the same edge that stable changes.
// Revision    : 1.0 - initial release
// ============================================================================
module nerv_debounce
  import nerv_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pressed;
  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign pressed = ACTIVE_LOW ? ~raw : raw;

  // Two-flop synchroniser bringing the asynchronous pin into the clock domain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pressed;
      sync_q <= meta_q;
    end
  end

  // Hold counter: any return to the stable level restarts the qualification
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
      rise     = sync_q;
      fall     = ~sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounced level and qualification counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : nerv_debounce
`default_nettype wire

// File: rtl/nerv_button_in.sv
`default_nettype none
// ============================================================================
// Module      : nerv_button_in
// Description : Board pushbutton input block for nervsoc. Debounces N_BTN
//               channels and exposes STATE / PRESS / RELEASE / IRQ_EN through
//               a four-word register window with a fixed one-cycle handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nerv_button_in
  import nerv_button_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             bus_valid,
  input  logic [3:0]       bus_addr,
  input  logic [3:0]       bus_wstrb,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready,
  output logic             irq
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  logic [N_BTN-1:0] press_q,   press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] irq_en_q,  irq_en_d;
  logic             ready_q,   ready_d;
  logic [31:0]      rdata_q,   rdata_d;
  logic             irq_q,     irq_d;

  logic             access;
  logic             is_write;
  logic [N_BTN-1:0] wr_bits;
  logic [N_BTN-1:0] wr_lanes;
  logic [31:0]      rd_word;
  logic             unused_bits;

  // Byte offset bits and data bits above the channel count carry no meaning
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  // One independent debouncer per button
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    nerv_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (btn_raw[i]),
      .stable  (stable[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // Per-channel write enable and data after byte-strobe qualification
  always_comb begin
    wr_bits  = '0;
    wr_lanes = '0;
    for (int i = 0; i < N_BTN; i++) begin
      wr_lanes[i] = bus_wstrb[i/8];
      wr_bits[i]  = bus_wdata[i] & bus_wstrb[i/8];
    end
  end

  // Register read mux: unused upper bits read as zero
  always_comb begin
    rd_word = '0;
    case (bus_addr[3:2])
      REG_STATE:   rd_word[N_BTN-1:0] = stable;
      REG_PRESS:   rd_word[N_BTN-1:0] = press_q;
      REG_RELEASE: rd_word[N_BTN-1:0] = release_q;
      default:     rd_word[N_BTN-1:0] = irq_en_q;
    endcase
  end

  // Next-state for handshake, sticky flags (set beats clear) and irq
  always_comb begin
    access    = bus_valid & ~ready_q;
    is_write  = access & (|bus_wstrb);
    ready_d   = access;
    rdata_d   = access ? rd_word : 32'd0;
    press_d   = press_q | rise;
    release_d = release_q | fall;
    irq_en_d  = irq_en_q;
    if (is_write) begin
      case (bus_addr[3:2])
        REG_PRESS:   press_d   = (press_q & ~wr_bits) | rise;
        REG_RELEASE: release_d = (release_q & ~wr_bits) | fall;
        REG_IRQ_EN:  irq_en_d  = (irq_en_q & ~wr_lanes) | wr_bits;
        default:     ;
      endcase
    end
    irq_d = |(press_q & irq_en_q);
  end

  // Register file, bus response and interrupt flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= '0;
      release_q <= '0;
      irq_en_q  <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      irq_en_q  <= irq_en_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule : nerv_button_in
`default_nettype wire

// File: tb/tb_nerv_button_in.sv
`default_nettype none
// ============================================================================
// Module      : tb_nerv_button_in
// Description : Directed self-checking bench for nerv_button_in with
//               DEBOUNCE_CYCLES=4, N_BTN=3, ACTIVE_LOW=1. Expected read data
//               is queued when an access is issued and compared on bus_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nerv_button_in;

  localparam int N_BTN = 3;
  localparam int DEB   = 4;

  localparam logic [3:0] A_STATE   = 4'h0;
  localparam logic [3:0] A_PRESS   = 4'h4;
  localparam logic [3:0] A_RELEASE = 4'h8;
  localparam logic [3:0] A_IRQ_EN  = 4'hC;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic [N_BTN-1:0] btn_raw   = 3'b111;
  logic             bus_valid = 1'b0;
  logic [3:0]       bus_addr  = 4'h0;
  logic [3:0]       bus_wstrb = 4'h0;
  logic [31:0]      bus_wdata = 32'h0;
  logic [31:0]      bus_rdata;
  logic             bus_ready;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clock = ~clock;

  nerv_button_in #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue one access at the next falling edge; data is captured by the DUT at
  // the following rising edge and must come back with bus_ready one cycle on.
  task automatic access(input string tag, input logic [3:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] exp);
    int          waited;
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clock);
    bus_valid = 1'b1;
    bus_addr  = addr;
    bus_wstrb = strb;
    bus_wdata = wdata;
    @(negedge clock);
    waited = 0;
    while (bus_ready !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, " latency"}, 32'(waited), 32'd0);
    check({t, " ready"}, {31'b0, bus_ready}, 32'd1);
    check(t, bus_rdata, e);
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    @(negedge clock);
    check({t, " ready drop"}, {31'b0, bus_ready}, 32'd0);
    check({t, " rdata idle"}, bus_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clock);
    check("rst ready", {31'b0, bus_ready}, 32'd0);
    check("rst irq", {31'b0, irq}, 32'd0);
    check("rst rdata", bus_rdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_neg(10);

    // All buttons released
    access("idle state",   A_STATE,   4'h0, 32'h0, 32'h0);
    access("idle press",   A_PRESS,   4'h0, 32'h0, 32'h0);
    access("idle release", A_RELEASE, 4'h0, 32'h0, 32'h0);
    check("idle irq", {31'b0, irq}, 32'd0);

    // Press btn 0: STATE flips on the 6th edge after the pin edge
    btn_raw[0] = 1'b0;
    wait_neg(4);
    access("b0 state edge6", A_STATE, 4'h0, 32'h0, 32'h0);
    access("b0 state",       A_STATE, 4'h0, 32'h0, 32'h1);
    access("b0 press",       A_PRESS, 4'h0, 32'h0, 32'h1);
    access("irqen wr",       A_IRQ_EN, 4'hF, 32'h1, 32'h0);
    check("irq on", {31'b0, irq}, 32'd1);
    access("press w1c",      A_PRESS, 4'hF, 32'h1, 32'h1);
    check("irq off", {31'b0, irq}, 32'd0);
    access("press cleared",  A_PRESS, 4'h0, 32'h0, 32'h0);

    // 3-cycle glitch on btn 1 must be rejected
    btn_raw[1] = 1'b0;
    wait_neg(3);
    btn_raw[1] = 1'b1;
    wait_neg(10);
    access("glitch state",   A_STATE,   4'h0, 32'h0, 32'h1);
    access("glitch press",   A_PRESS,   4'h0, 32'h0, 32'h0);
    access("glitch release", A_RELEASE, 4'h0, 32'h0, 32'h0);

    // Press btn 2: STATE must show it at the 7th edge
    btn_raw[2] = 1'b0;
    wait_neg(5);
    access("b2 state edge7", A_STATE, 4'h0, 32'h0, 32'h5);
    wait_neg(2);
    btn_raw[2] = 1'b1;
    wait_neg(12);
    access("b2 press",   A_PRESS,   4'h0, 32'h0, 32'h4);
    access("b2 release", A_RELEASE, 4'h0, 32'h0, 32'h4);
    access("b2 state",   A_STATE,   4'h0, 32'h0, 32'h1);

    // W1C on RELEASE coinciding with a new fall pulse: set wins
    btn_raw[2] = 1'b0;
    wait_neg(12);
    access("rel w1c",     A_RELEASE, 4'hF, 32'h4, 32'h4);
    access("rel cleared", A_RELEASE, 4'h0, 32'h0, 32'h0);
    btn_raw[2] = 1'b1;
    wait_neg(4);
    access("rel w1c race", A_RELEASE, 4'hF, 32'h4, 32'h0);
    access("rel set wins", A_RELEASE, 4'h0, 32'h0, 32'h4);

    // Reset in the middle of a btn 0 debounce
    btn_raw[0] = 1'b1;
    wait_neg(12);
    access("irqen wr5", A_IRQ_EN, 4'hF, 32'h5, 32'h1);
    check("irq pre-reset", {31'b0, irq}, 32'd1);
    btn_raw[0] = 1'b0;
    wait_neg(4);
    reset_n = 1'b0;
    #1;
    check("async rst irq", {31'b0, irq}, 32'd0);
    check("async rst ready", {31'b0, bus_ready}, 32'd0);
    check("async rst rdata", bus_rdata, 32'd0);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(4);
    access("post rst press edge6", A_PRESS,   4'h0, 32'h0, 32'h0);
    access("post rst press",       A_PRESS,   4'h0, 32'h0, 32'h1);
    access("post rst release",     A_RELEASE, 4'h0, 32'h0, 32'h0);
    access("post rst irqen",       A_IRQ_EN,  4'h0, 32'h0, 32'h0);
    check("post rst irq", {31'b0, irq}, 32'd0);

    // Byte strobes, IRQ_EN width and read-only STATE
    access("irqen strb0",  A_IRQ_EN, 4'h1, 32'hFFFF_FFFF, 32'h0);
    access("irqen rd7",    A_IRQ_EN, 4'h0, 32'h0, 32'h7);
    access("irqen strb1",  A_IRQ_EN, 4'h2, 32'h0, 32'h7);
    access("irqen keep7",  A_IRQ_EN, 4'h0, 32'h0, 32'h7);
    check("irq final", {31'b0, irq}, 32'd1);
    access("state wr",     A_STATE,  4'hF, 32'hFFFF_FFFF, 32'h1);
    access("state ro",     A_STATE,  4'h0, 32'h0, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nerv_button_in
`default_nettype wire
